// File: rtl/qkv_pkg.sv
// Shared constants, FSM state type and saturation helper for the
// time-multiplexed Q/K/V projection sequencer.
package qkv_pkg;

    // Geometry of one projection job
    localparam int N_IN  = 16;   // input elements per vector
    localparam int N_OUT = 6;    // output elements per matrix
    localparam int N_MAT = 3;    // Q, K, V
    localparam int DW    = 16;   // element and weight width (signed)
    localparam int ACC_W = 40;   // accumulator width
    localparam int OUT_W = 32;   // saturated output width

    // Total number of weight fetches per job (3 * 6 * 16)
    localparam int N_WEIGHTS = N_MAT * N_OUT * N_IN;
    localparam logic [8:0] LAST_ADDR = 9'(N_WEIGHTS - 1);

    // Matrix indices as used in the weight address and overflow bits
    localparam logic [1:0] Q = 2'd0;
    localparam logic [1:0] K = 2'd1;
    localparam logic [1:0] V = 2'd2;

    // Last column / row indices of the address walk
    localparam logic [3:0] LAST_COL = 4'(N_IN - 1);
    localparam logic [2:0] LAST_ROW = 3'(N_OUT - 1);

    // Signed 32-bit limits expressed at accumulator width
    localparam logic signed [ACC_W-1:0] SAT_MAX = 40'sh00_7FFF_FFFF;
    localparam logic signed [ACC_W-1:0] SAT_MIN = 40'shFF_8000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [OUT_W-1:0] value;
        logic             ovf;
    } sat_t;

    // Clamp a 40-bit signed sum into the signed 32-bit range; ovf flags a clamp
    function automatic sat_t sat32(input logic signed [ACC_W-1:0] sum);
        sat_t r;
        if (sum > SAT_MAX) begin
            r.value = 32'h7FFF_FFFF;
            r.ovf   = 1'b1;
        end else if (sum < SAT_MIN) begin
            r.value = 32'h8000_0000;
            r.ovf   = 1'b1;
        end else begin
            r.value = sum[OUT_W-1:0];
            r.ovf   = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/qkv_mac_unit.sv
// Single 16x16 signed multiply-accumulate with saturation. Runs one cycle
// behind the weight address stream: the issue tags are registered so they
// line up with w_rdata returned by the synchronous weight memory.
module qkv_mac_unit
    import qkv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  issue,
    input  logic [1:0]            issue_mat,
    input  logic [2:0]            issue_row,
    input  logic [3:0]            issue_col,
    input  logic [N_IN*DW-1:0]    x_vec,
    input  logic [DW-1:0]         w_rdata,
    output logic                  wr_en,
    output logic [1:0]            wr_mat,
    output logic [2:0]            wr_row,
    output logic [OUT_W-1:0]      wr_data,
    output logic                  wr_ovf
);

    logic                    valid_d;
    logic [1:0]              mat_d;
    logic [2:0]              row_d;
    logic [3:0]              col_d;
    logic signed [ACC_W-1:0] acc;

    logic [DW-1:0]           x_el;
    logic signed [2*DW-1:0]  w_ext;
    logic signed [2*DW-1:0]  x_ext;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum;
    sat_t                    sat;

    // Register the issue tags so they align with the returned weight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_d <= 1'b0;
            mat_d   <= 2'd0;
            row_d   <= 3'd0;
            col_d   <= 4'd0;
        end else begin
            valid_d <= issue;
            mat_d   <= issue_mat;
            row_d   <= issue_row;
            col_d   <= issue_col;
        end
    end

    // Multiply, then load (first column) or accumulate, then saturate
    always_comb begin
        // Element col_d lives at bits [16*col_d +: 16]; {col_d, 4'b0} is 16*col_d
        x_el     = x_vec[{col_d, 4'b0000} +: DW];
        w_ext    = {{DW{w_rdata[DW-1]}}, w_rdata};
        x_ext    = {{DW{x_el[DW-1]}}, x_el};
        prod     = w_ext * x_ext;
        prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
        sum      = (col_d == 4'd0) ? prod_ext : (acc + prod_ext);
        sat      = sat32(sum);
    end

    // Accumulator: cleared at job start, updated on every returned weight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (valid_d) begin
            acc <= sum;
        end
    end

    // A result is complete on the last column of each row
    always_comb begin
        wr_en   = valid_d && (col_d == LAST_COL);
        wr_mat  = mat_d;
        wr_row  = row_d;
        wr_data = sat.value;
        wr_ovf  = sat.ovf;
    end

endmodule

// File: rtl/qkv_sequencer.sv
// Time-multiplexed Q/K/V projection controller. Accepts one input vector,
// walks all 288 weights through a single MAC, and presents saturated
// Q/K/V vectors plus per-matrix overflow flags until the consumer takes them.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE (and never during reset);
// out_valid is high only in DONE and the results hold steady until
// out_ready is seen. in_valid outside IDLE is ignored, nothing is buffered.
module qkv_sequencer
    import qkv_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*DW-1:0]     in_vector,
    output logic                   w_en,
    output logic [8:0]             w_addr,
    input  logic [DW-1:0]          w_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_OUT*OUT_W-1:0] q_out,
    output logic [N_OUT*OUT_W-1:0] k_out,
    output logic [N_OUT*OUT_W-1:0] v_out,
    output logic [2:0]             overflow,
    output logic                   busy,
    output state_t                 fsm_state
);

    state_t state;
    state_t state_nx;

    logic accept;
    logic release_out;
    logic issue_last;

    logic [1:0]          mat_cnt;
    logic [2:0]          row_cnt;
    logic [3:0]          col_cnt;
    logic [N_IN*DW-1:0]  x_reg;

    logic                wr_en;
    logic [1:0]          wr_mat;
    logic [2:0]          wr_row;
    logic [OUT_W-1:0]    wr_data;
    logic                wr_ovf;
    logic [2:0]          ovf_set;

    logic [OUT_W-1:0]    res [N_MAT][N_OUT];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: fixed-length walk, then wait for the consumer
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept)      state_nx = S_RUN;
            S_RUN:   if (issue_last)  state_nx = S_DRAIN;
            S_DRAIN:                  state_nx = S_DONE;
            S_DONE:  if (release_out) state_nx = S_IDLE;
            default:                  state_nx = S_IDLE;
        endcase
    end

    // Output decode; in_ready is masked by rst so it reads low during reset
    always_comb begin
        in_ready    = (state == S_IDLE) && !rst;
        w_en        = (state == S_RUN);
        out_valid   = (state == S_DONE);
        busy        = (state != S_IDLE);
        accept      = in_valid && in_ready;
        release_out = out_valid && out_ready;
        issue_last  = w_en && (w_addr == LAST_ADDR);
        fsm_state   = state;
    end

    // Address walk: mat outer, row middle, col inner; w_addr holds outside RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_addr  <= 9'd0;
            mat_cnt <= Q;
            row_cnt <= 3'd0;
            col_cnt <= 4'd0;
        end else if (accept) begin
            w_addr  <= 9'd0;
            mat_cnt <= Q;
            row_cnt <= 3'd0;
            col_cnt <= 4'd0;
        end else if (w_en && !issue_last) begin
            w_addr  <= w_addr + 9'd1;
            col_cnt <= col_cnt + 4'd1;
            if (col_cnt == LAST_COL) begin
                if (row_cnt == LAST_ROW) begin
                    row_cnt <= 3'd0;
                    mat_cnt <= mat_cnt + 2'd1;
                end else begin
                    row_cnt <= row_cnt + 3'd1;
                end
            end
        end
    end

    // Input latch: the vector is captured once at accept and held for the job
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg <= '0;
        end else if (accept) begin
            x_reg <= in_vector;
        end
    end

    qkv_mac_unit u_mac (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept),
        .issue     (w_en),
        .issue_mat (mat_cnt),
        .issue_row (row_cnt),
        .issue_col (col_cnt),
        .x_vec     (x_reg),
        .w_rdata   (w_rdata),
        .wr_en     (wr_en),
        .wr_mat    (wr_mat),
        .wr_row    (wr_row),
        .wr_data   (wr_data),
        .wr_ovf    (wr_ovf)
    );

    // One-hot overflow contribution of the row being written
    always_comb begin
        ovf_set = '0;
        if (wr_en && wr_ovf) begin
            ovf_set = 3'b001 << wr_mat;
        end
    end

    // Sticky per-job overflow flags, cleared when a new vector is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 3'b000;
        end else if (accept) begin
            overflow <= 3'b000;
        end else begin
            overflow <= overflow | ovf_set;
        end
    end

    // Result registers: each element is written once, on its last column
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < N_MAT; m++) begin
                for (int j = 0; j < N_OUT; j++) begin
                    res[m][j] <= '0;
                end
            end
        end else if (wr_en) begin
            res[wr_mat][wr_row] <= wr_data;
        end
    end

    // Pack result registers onto the flat output buses
    always_comb begin
        q_out = '0;
        k_out = '0;
        v_out = '0;
        for (int j = 0; j < N_OUT; j++) begin
            q_out[j*OUT_W +: OUT_W] = res[Q][j];
            k_out[j*OUT_W +: OUT_W] = res[K][j];
            v_out[j*OUT_W +: OUT_W] = res[V][j];
        end
    end

endmodule

// File: tb/tb_qkv_sequencer.sv
// Directed bench for qkv_sequencer: weight memory model, scoreboard of
// expected Q/K/V/overflow results, latency and address-stream checks.
module tb_qkv_sequencer;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [255:0]   in_vector;
    logic           w_en;
    logic [8:0]     w_addr;
    logic [15:0]    w_rdata;
    logic           out_valid;
    logic           out_ready;
    logic [191:0]   q_out;
    logic [191:0]   k_out;
    logic [191:0]   v_out;
    logic [2:0]     overflow;
    logic           busy;
    qkv_pkg::state_t fsm_state;

    int checks = 0;
    int errors = 0;

    logic [15:0]    wmem [288];
    logic [255:0]   xv;
    // Layout: [578:576] overflow, [575:384] V, [383:192] K, [191:0] Q
    logic [578:0]   exp_q [$];

    qkv_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vector (in_vector),
        .w_en      (w_en),
        .w_addr    (w_addr),
        .w_rdata   (w_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_out     (q_out),
        .k_out     (k_out),
        .v_out     (v_out),
        .overflow  (overflow),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous weight memory: data valid the cycle after w_en
    always @(posedge clk) begin
        if (w_en) w_rdata <= wmem[w_addr];
    end

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result from the bench's own weight and vector copies
    function automatic logic [578:0] model();
        logic [578:0] r;
        longint s;
        logic [31:0] val;
        r = '0;
        for (int m = 0; m < 3; m++) begin
            for (int rw = 0; rw < 6; rw++) begin
                s = 0;
                for (int c = 0; c < 16; c++) begin
                    s += longint'($signed(wmem[m*96 + rw*16 + c])) * longint'($signed(xv[c*16 +: 16]));
                end
                if (s > 64'sd2147483647) begin
                    val = 32'h7FFF_FFFF;
                    r[576 + m] = 1'b1;
                end else if (s < -64'sd2147483648) begin
                    val = 32'h8000_0000;
                    r[576 + m] = 1'b1;
                end else begin
                    val = s[31:0];
                end
                r[m*192 + rw*32 +: 32] = val;
            end
        end
        return r;
    endfunction

    task automatic set_w(input int m, input logic [15:0] val);
        for (int c = 0; c < 96; c++) wmem[m*96 + c] = val;
    endtask

    task automatic set_x(input logic [15:0] val);
        for (int c = 0; c < 16; c++) xv[c*16 +: 16] = val;
    endtask

    task automatic rand_small();
        int r;
        for (int i = 0; i < 288; i++) begin
            r = int'($urandom_range(200)) - 100;
            wmem[i] = r[15:0];
        end
        for (int c = 0; c < 16; c++) begin
            r = int'($urandom_range(2000)) - 1000;
            xv[c*16 +: 16] = r[15:0];
        end
    endtask

    // Drive one job; rst_at>0 asserts reset at that cycle after accept
    task automatic run_job(input int rst_at);
        int n;
        int bad;
        int lat;
        logic [578:0] e;
        exp_q.push_back(model());
        @(negedge clk);
        in_vector = xv;
        in_valid  = 1'b1;
        check("in_ready_at_accept", 192'(in_ready), 192'd1);
        @(negedge clk);
        in_valid = 1'b0;
        n   = 1;
        bad = 0;
        lat = -1;
        while (n <= 400) begin
            if (rst_at > 0 && n == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_mid_ctrl", 192'({out_valid, busy, w_en, in_ready, w_addr, overflow}), 192'd0);
                check("rst_mid_data", q_out | k_out | v_out, 192'd0);
                e = exp_q.pop_back();
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                check("rst_mid_in_ready", 192'({in_ready, busy}), 192'b10);
                return;
            end
            if (out_valid) begin
                lat = n;
                break;
            end
            if (n <= 288) begin
                if (w_en !== 1'b1 || w_addr !== 9'(n - 1) || busy !== 1'b1) bad++;
            end else begin
                if (w_en !== 1'b0 || busy !== 1'b1) bad++;
            end
            @(negedge clk);
            n++;
        end
        check("w_addr_seq", 192'(bad), 192'd0);
        check("latency", 192'(lat), 192'd290);
        e = exp_q.pop_front();
        check("q_out", q_out, e[191:0]);
        check("k_out", k_out, e[383:192]);
        check("v_out", v_out, e[575:384]);
        check("overflow", 192'(overflow), 192'(e[578:576]));
    endtask

    // Complete the output handshake and confirm the return to IDLE
    task automatic take_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_handshake", 192'({in_ready, out_valid, busy, w_en}), 192'b1000);
        check("w_addr_hold", 192'(w_addr), 192'd287);
    endtask

    initial begin
        logic [191:0] q_s;
        logic [191:0] k_s;
        logic [191:0] v_s;
        logic [2:0]   o_s;
        int bad;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_vector = '0;
        out_ready = 1'b0;
        xv        = '0;
        for (int i = 0; i < 288; i++) wmem[i] = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ctrl", 192'({in_ready, out_valid, busy, w_en, w_addr, overflow}), 192'd0);
        check("rst_data", q_out | k_out | v_out, 192'd0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 192'(in_ready), 192'd1);

        // All ones: every element is 16
        for (int m = 0; m < 3; m++) set_w(m, 16'h0001);
        set_x(16'h0001);
        run_job(0);
        check("ones_q_direct", q_out, {6{32'd16}});
        take_result();

        // Q saturates positive, K/V zero
        set_w(0, 16'h7FFF);
        set_w(1, 16'h0000);
        set_w(2, 16'h0000);
        set_x(16'h7FFF);
        run_job(0);
        check("qsat_q_direct", q_out, {6{32'h7FFF_FFFF}});
        check("qsat_ovf_direct", 192'(overflow), 192'(3'b001));
        take_result();

        // V saturates negative
        set_w(0, 16'h0000);
        set_w(2, 16'h8000);
        run_job(0);
        check("vsat_v_direct", v_out, {6{32'h8000_0000}});
        check("vsat_ovf_direct", 192'(overflow), 192'(3'b100));
        take_result();

        // Benign data after an overflow job: flags must clear
        rand_small();
        run_job(0);
        check("benign_ovf_direct", 192'(overflow), 192'd0);
        take_result();

        // Single nonzero weight: K row 2 col 5 = 3, x[5] = -2
        for (int m = 0; m < 3; m++) set_w(m, 16'h0000);
        wmem[96 + 2*16 + 5] = 16'd3;
        rand_small_x: for (int c = 0; c < 16; c++) xv[c*16 +: 16] = 16'($urandom_range(65535));
        xv[80 +: 16] = 16'hFFFE;
        run_job(0);
        check("k2_direct", 192'(k_out[64 +: 32]), 192'(32'hFFFF_FFFA));
        check("k2_others", {k_out[191:96], k_out[63:0]} | q_out[95:0], 192'd0);
        take_result();

        // Backpressure: hold out_ready low, pulse in_valid, outputs must hold
        rand_small();
        run_job(0);
        q_s = q_out;
        k_s = k_out;
        v_s = v_out;
        o_s = overflow;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            in_valid  = (i % 7 == 0);
            in_vector = {8{32'($urandom)}};
            if (q_out !== q_s || k_out !== k_s || v_out !== v_s || overflow !== o_s) bad++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || w_en !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        check("backpressure_hold", 192'(bad), 192'd0);
        take_result();
        @(negedge clk);
        check("no_ghost_job", 192'({busy, w_en}), 192'd0);

        // Reset mid-job, then a fresh full-range job
        for (int i = 0; i < 288; i++) wmem[i] = 16'($urandom_range(65535));
        for (int c = 0; c < 16; c++) xv[c*16 +: 16] = 16'($urandom_range(65535));
        run_job(150);
        check("queue_after_rst", 192'(exp_q.size()), 192'd0);
        run_job(0);
        take_result();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qkv_sequencer.md
# qkv_sequencer

Time-multiplexed controller for the fusion-core Q/K/V projection. It accepts one 256-bit normalized vector over a valid/ready handshake. It then sequences a single 16×16 signed MAC through the Q, K and V weight matrices (6 rows × 16 columns each), fetched from an external synchronous weight memory. It returns saturated 6×32-bit Q, K and V vectors with per-matrix overflow flags, and replaces the fully parallel 288-multiplier projection wherever area matters more than latency.

## Interface
- N_IN, 16: input elements per vector
- N_OUT, 6: output elements per matrix
- DW, 16: element and weight width (signed)
- ACC_W, 40: accumulator width
- OUT_W, 32: saturated output width
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector
- in_vector  in  256  element i = bits [16i+15:16i], signed
- w_en  out  1  weight memory read enable
- w_addr  out  9  weight index, mat*96 + row*16 + col
- w_rdata  in  16  signed weight, valid the cycle after w_en
- out_valid  out  1  Q/K/V result valid
- out_ready  in  1  consumer accepts result
- q_out, k_out, v_out  out  192 each  element j = bits [32j+31:32j]
- overflow  out  3  bit0 Q, bit1 K, bit2 V; sticky per job
- busy  out  1  high in RUN, DRAIN or DONE

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch in_vector, clear the accumulator, clear overflow, and move to RUN.
- RUN: issue w_en=1 with w_addr = 0..287, one per cycle. Order is mat Q=0, K=1, V=2, then row 0..5, then col 0..15. After address 287, move to DRAIN.
- DRAIN: one cycle in which the last weight returns. Then move to DONE.
- Datapath, one cycle behind the address stream:
  - Product = w_rdata × x[col_d], 32-bit signed, sign-extended to ACC_W.
  - At col_d=0, the accumulator loads the product; otherwise it adds the product.
  - At col_d=15, the final sum (accumulator + product) is saturated and written to element row_d of the matrix mat_d.
- Saturation rule:
  - A sum > 2^31−1 gives 0x7FFFFFFF; a sum < −2^31 gives 0x80000000. Either case sets overflow[mat_d].
  - Otherwise the result is the low 32 bits.
  - ACC_W=40 cannot wrap: 16 × 2^30 < 2^39.
- DONE: out_valid=1. Outputs and overflow stay stable until out_valid&out_ready, then the block returns to IDLE.
- in_valid outside IDLE is ignored; no input is buffered.
- w_en=0 and w_addr holds its last value outside RUN.

## Timing
- Reset values: in_ready=0 while rst is asserted and 1 in the first cycle after release; out_valid=0, busy=0, w_en=0, w_addr=0, q_out/k_out/v_out=0, overflow=0.
- Let cycle 0 be the accept cycle. w_en is high in cycles 1–288, DRAIN is cycle 289, and out_valid rises at cycle 290.
- The latency of 290 cycles is fixed and independent of data and backpressure.
- The throughput limit is one vector per 291 cycles, with out_ready tied high. in_ready is high again in the cycle after the output handshake.
- Each result register (q_out/k_out/v_out element) updates exactly at its col_d=15 cycle. q_out, k_out and v_out are only meaningful while out_valid=1.
- Reset mid-job: the block returns to IDLE immediately. The partial job is discarded and no out_valid is produced.
- Reset while out_valid=1: out_valid drops immediately and the result is lost.

## Structure
- Package qkv_pkg holds:
  - the N_IN, N_OUT, DW, ACC_W and OUT_W constants;
  - the state enum type;
  - the matrix index constants Q=0, K=1, V=2;
  - the sat32 function (40-bit in → 32-bit value plus flag).
- Sub-module qkv_mac_unit: the single multiply, the accumulate/load select and the saturation, with the registered mat_d/row_d/col_d tags. The top level keeps the FSM, address counters, input latch and output registers.

## Test plan
- All weights 0x0001, all x 0x0001 → every q/k/v element = 16, overflow=0, out_valid exactly 290 cycles after the accept.
- Q weights 0x7FFF, x 0x7FFF, K/V weights 0 → q elements 0x7FFFFFFF, k/v elements 0, overflow=3'b001.
- V weights 0x8000, x 0x7FFF → v elements 0x80000000, overflow=3'b100. Then a second job with benign data → overflow=0.
- K row 2 col 5 = 3, other weights 0, x[5]=0xFFFE (−2) → k element 2 = 0xFFFFFFFA, all other elements 0. The bench checks the w_addr sequence 0..287 is issued with no gaps.
- Hold out_ready=0 for 50 cycles after out_valid → outputs stable, in_ready=0, in_valid pulses ignored. Release out_ready → in_ready=1 the next cycle.
- Assert rst at cycle 150 of a job → all outputs at their reset values immediately. A fresh job after release produces the correct result.
